ethtx_sched: RTL
================

// Module: ethtx_sched
// PURPOSE
//  Transmit scheduler in front of the Ethernet TX frame engine.
//  Shares one transmitter between two frame sources: 0 = host/descriptor buffer, 1 = internal control frame.
//  Arbitrates round-robin and selects the TX buffer, byte count and skip flag.
//  Sequences the engine's txena/txdone handshake and recovers a hung engine via a timeout and a local clear.
// PARAMETERS
//  MAXLEN   1514  max frame length in bytes, excluding CRC (CRC is appended by the engine)
//  TMO_CYC  4096  clk cycles allowed from txena rise to txdone before abort
//  TMOW     13    width of timeout counter; must satisfy 2**TMOW > TMO_CYC
// PORTS
//  clk      in   1   clock; all logic on posedge (engine samples on negedge)
//  clr      in   1   asynchronous reset, active-high
//  req      in   2   per-source request, level; held until done/err pulse seen
//  len0     in   11  source 0 frame length, bytes
//  len1     in   11  source 1 frame length, bytes
//  skip0    in   1   source 0 skips first byte of buffer
//  skip1    in   1   source 1 skips first byte of buffer
//  gnt      out  2   one-hot grant, high from START through DRAIN
//  done     out  2   1-cycle pulse: frame of source n sent
//  err      out  2   1-cycle pulse: frame of source n rejected or timed out
//  bufsel   out  1   TX buffer mux select (id of granted source)
//  txcntb   out  11  to engine: two's-complement byte count, 11'h000 - len
//  skipb    out  1   to engine: latched skip flag
//  txena    out  1   to engine: start/hold frame
//  txdone   in   1   from engine: frame complete
//  txclr    out  1   to engine clear input, 1-cycle pulse on timeout
//  busy     out  1   high whenever state != IDLE
//  nframes  out  16  count of successfully sent frames, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (clr=1): state=IDLE.
//   All outputs 0 (gnt, done, err, bufsel, txcntb, skipb, txena, txclr, busy, nframes).
//   Last-served pointer lp=1, so source 0 wins the first tie.
//   Reset mid-frame drops txena at once; no done/err pulse is issued.
//  IDLE: on any req bit set, grant id = (req==2'b11) ? ~lp : (req[1] ? 1 : 0).
//   Latch len/skip of id; next state CHECK.
//  CHECK: if len==0 or len>MAXLEN: err[id]=1 for 1 cycle, go RELEASE.
//   Otherwise: txcntb <= 11'h000-len, skipb <= skip, bufsel <= id, gnt[id] <= 1, go START.
//  START: txena <= 1, timeout counter cleared, go WAIT.
//   txena rises 3 clk after req is seen in IDLE.
//  WAIT: counter increments each cycle.
//   txdone=1: txena <= 0, done[id] pulse, nframes+1, go DRAIN.
//   counter==TMO_CYC-1 and no txdone: txena <= 0, err[id] pulse, txclr pulse, go DRAIN.
//   txdone and timeout in the same cycle: txdone wins (done, not err).
//  DRAIN: wait for txdone==0 and req[id]==0, then gnt <= 0, lp <= id, go IDLE.
//   Other source's req is ignored until then.
//  RELEASE: wait for req[id]==0, then lp <= id, go IDLE (no grant was given).
//  txcntb, skipb and bufsel are stable from CHECK exit until DRAIN exit.
//   len/skip inputs may change after CHECK without effect.
//  Single source requesting repeatedly is served back-to-back.
//   Minimum gap is engine IFG + 3 clk.
// TESTING
//  T1 req=01, len0=64, skip0=0 -> txcntb=11'h7C0, bufsel=0, txena high 3 clk later.
//     Bench txdone -> done=01 1 cycle, nframes=1.
//  T2 after reset req=11 -> source 0 served first, then source 1 (gnt 01 then 10).
//     Repeat req=11 -> order 0,1,0,1.
//  T3 req=10, len1=0 -> err=10 pulse, txena never rises.
//     Repeat with len1=1515 -> err=10 pulse.
//  T4 req=01, len0=1514, txdone held 0 -> at 4096 clk: err=01, txclr 1-cycle pulse.
//     txena=0, nframes unchanged.
//  T5 clr asserted in WAIT -> txena/gnt/busy 0 immediately.
//     Next req=11 grants source 0.
//  T6 txdone held 1 while req stays high -> stays DRAIN; only 1 done pulse, no second frame.

Source files
------------

// File: rtl/ethtx_sched.sv
// Round-robin transmit scheduler for two frame sources in front of the TX frame engine;
// sequences txena/txdone, checks frame length and aborts a hung engine with txclr.
module ethtx_sched #(
  parameter int MAXLEN  = 1514,
  parameter int TMO_CYC = 4096,
  parameter int TMOW    = 13
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  req,
  input  logic [10:0] len0,
  input  logic [10:0] len1,
  input  logic        skip0,
  input  logic        skip1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        bufsel,
  output logic [10:0] txcntb,
  output logic        skipb,
  output logic        txena,
  input  logic        txdone,
  output logic        txclr,
  output logic        busy,
  output logic [15:0] nframes
);

  typedef enum logic [2:0] {IDLE, CHECK, START, WAIT, DRAIN, RELEASE} state_t;

  state_t            state;
  logic              lp;
  logic              id;
  logic              nxt_id;
  logic [10:0]       len_q;
  logic              skip_q;
  logic [TMOW-1:0]   tmo_cnt;

  // Ties go to the source not served last; a lone requester always wins.
  assign nxt_id = (req == 2'b11) ? ~lp : req[1];
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      lp      <= 1'b1;
      id      <= 1'b0;
      len_q   <= '0;
      skip_q  <= 1'b0;
      tmo_cnt <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      bufsel  <= 1'b0;
      txcntb  <= '0;
      skipb   <= 1'b0;
      txena   <= 1'b0;
      txclr   <= 1'b0;
      nframes <= '0;
    end else begin
      done  <= '0;
      err   <= '0;
      txclr <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            id     <= nxt_id;
            len_q  <= nxt_id ? len1 : len0;
            skip_q <= nxt_id ? skip1 : skip0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (len_q == 11'd0 || len_q > 11'(MAXLEN)) begin
            err[id] <= 1'b1;
            state   <= RELEASE;
          end else begin
            txcntb <= 11'h000 - len_q;
            skipb  <= skip_q;
            bufsel <= id;
            gnt    <= id ? 2'b10 : 2'b01;
            state  <= START;
          end
        end
        START: begin
          txena   <= 1'b1;
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A completion in the last allowed cycle still counts as sent.
          if (txdone) begin
            txena    <= 1'b0;
            done[id] <= 1'b1;
            nframes  <= nframes + 16'd1;
            state    <= DRAIN;
          end else if (tmo_cnt == TMOW'(TMO_CYC - 1)) begin
            txena   <= 1'b0;
            err[id] <= 1'b1;
            txclr   <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (!txdone && !req[id]) begin
            gnt   <= '0;
            lp    <= id;
            state <= IDLE;
          end
        end
        RELEASE: begin
          if (!req[id]) begin
            lp    <= id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
